// File: rtl/cla_adder32.sv
// rtl/cla_adder32.sv - two-level carry-lookahead 32-bit adder with registered result copy
//
// Purpose: integer add unit for the ALU datapath. The sum is built from
// 4-bit carry-lookahead groups whose group propagate/generate terms feed a
// second-level lookahead unit, so no carry ripples from group to group.
//
// Ports:
//   clk     in   1      clock; rising edge updates sum_q/cout_q/ovf_q only
//   rst_n   in   1      asynchronous active-low reset of the registered outputs
//   a       in   WIDTH  operand A (unsigned or two's complement)
//   b       in   WIDTH  operand B (unsigned or two's complement)
//   sum     out  WIDTH  combinational (a + b) mod 2^WIDTH
//   cout    out  1      combinational carry out of bit WIDTH-1
//   ovf     out  1      combinational signed overflow
//   sum_q   out  WIDTH  sum registered on rising clk
//   cout_q  out  1      cout registered on rising clk
//   ovf_q   out  1      ovf registered on rising clk

module cla_adder32 #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    pg;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;      // gc[k] = carry into group k; gc[NG] = cout
  logic             la_run;
  logic             la_acc;

  assign p = a ^ b;
  assign g = a & b;

  // First level: each 4-bit group derives its internal carries directly from
  // its own p/g and the group carry-in, and exports (PG, GG) upward.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int B = gi * GROUP;

    assign c[B]   = gc[gi];
    assign c[B+1] = g[B]
                  | (p[B] & gc[gi]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & gc[gi]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[gi]);

    assign pg[gi] = &p[B+GROUP-1:B];
    assign gg[gi] = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
  end

  // Second level: every group carry-in is an independent sum-of-products over
  // the lower groups' (PG, GG); it never reads another group's carry. With
  // c0 fixed at 0 there is no carry-in term.
  always_comb begin
    gc     = '0;
    la_run = 1'b1;
    la_acc = 1'b0;
    for (int k = 1; k <= NG; k++) begin
      la_run = 1'b1;
      la_acc = 1'b0;
      for (int j = k - 1; j >= 0; j--) begin
        la_acc = la_acc | (la_run & gg[j]);
        la_run = la_run & pg[j];
      end
      gc[k] = la_acc;
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];
  assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_cla_adder32.sv
// tb/tb_cla_adder32.sv - self-checking bench for cla_adder32

module tb_cla_adder32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;

  int checks;
  int failures;

  logic [31:0] exp_sum;
  logic        exp_cout;
  logic        exp_ovf;

  cla_adder32 #(.WIDTH(32), .GROUP(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit unsigned and signed arithmetic.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb);
    logic [32:0] us;
    logic signed [32:0] ss;
    us = {1'b0, ma} + {1'b0, mb};
    ss = $signed({ma[31], ma}) + $signed({mb[31], mb});
    exp_sum  = us[31:0];
    exp_cout = us[32];
    exp_ovf  = (ss > 33'sd2147483647) || (ss < -33'sd2147483648);
  endtask

  task automatic apply_and_check(input string name, input logic [31:0] va, input logic [31:0] vb);
    a = va;
    b = vb;
    model(va, vb);
    #1;
    checks++;
    if ({sum, cout, ovf} !== {exp_sum, exp_cout, exp_ovf}) begin
      failures++;
      $display("FAIL %s a=%h b=%h got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, va, vb, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a = 32'h0;
    b = 32'h0;
    #3;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 34'h0) begin
      failures++;
      $display("FAIL reset_regs got sum_q=%h cout_q=%b ovf_q=%b want 0", sum_q, cout_q, ovf_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_and_check("zero", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 34'h0) begin
      failures++;
      $display("FAIL zero_regs got sum_q=%h cout_q=%b ovf_q=%b want 0", sum_q, cout_q, ovf_q);
    end
  endtask

  task automatic test_directed;
    apply_and_check("full_carry", 32'hFFFF_FFFF, 32'h0000_0001);
    apply_and_check("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001);
    apply_and_check("neg_ovf",    32'h8000_0000, 32'h8000_0000);
    apply_and_check("all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply_and_check("neg_no_ovf", 32'hFFFF_FFFE, 32'h0000_0001);
    // Fixed literal expectations guard the model itself on the key corners.
    a = 32'hFFFF_FFFF; b = 32'h1; #1;
    checks++;
    if ({sum, cout, ovf} !== {32'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_carry_lit got %h/%b/%b want 00000000/1/0", sum, cout, ovf);
    end
    a = 32'h7FFF_FFFF; b = 32'h1; #1;
    checks++;
    if ({sum, cout, ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pos_ovf_lit got %h/%b/%b want 80000000/0/1", sum, cout, ovf);
    end
  endtask

  task automatic test_group_boundaries;
    apply_and_check("grp0", 32'h0000_000F, 32'h0000_0001);
    apply_and_check("grp6", 32'h0FFF_FFFF, 32'h0000_0001);
    apply_and_check("mix",  32'h1234_5678, 32'h8765_4321);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] m;
      m = (32'h1 << (4 * k + 4)) - 32'h1;
      apply_and_check("grp_walk", m, 32'h1);
    end
    a = 32'h1234_5678; b = 32'h8765_4321; #1;
    checks++;
    if ({sum, cout} !== {32'h9999_9999, 1'b0}) begin
      failures++;
      $display("FAIL mix_lit got %h/%b want 99999999/0", sum, cout);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      apply_and_check("random", ra, rb);
    end
  endtask

  task automatic test_registered;
    logic [31:0] pa;
    logic [31:0] pb;
    @(negedge clk);
    a = 32'd5;
    b = 32'd7;
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== 32'd12) begin
      failures++;
      $display("FAIL reg_capture got sum_q=%h want 0000000c", sum_q);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum_q !== 32'd0 || cout_q !== 1'b0 || ovf_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_async_reset got sum_q=%h want 00000000", sum_q);
    end
    checks++;
    if (sum !== 32'd12) begin
      failures++;
      $display("FAIL comb_during_reset got sum=%h want 0000000c", sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== 32'd0) begin
      failures++;
      $display("FAIL reg_hold_in_reset got sum_q=%h want 00000000", sum_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (sum_q !== 32'd0) begin
      failures++;
      $display("FAIL reg_before_edge got sum_q=%h want 00000000", sum_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum_q !== 32'd12) begin
      failures++;
      $display("FAIL reg_after_release got sum_q=%h want 0000000c", sum_q);
    end
    // Back-to-back: each edge captures the operands applied in that cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pa = (i == 0) ? 32'h8000_0000 : $urandom;
      pb = (i == 0) ? 32'h8000_0000 : $urandom;
      a = pa;
      b = pb;
      model(pa, pb);
      @(posedge clk);
      #1;
      checks++;
      if ({sum_q, cout_q, ovf_q} !== {exp_sum, exp_cout, exp_ovf}) begin
        failures++;
        $display("FAIL reg_stream a=%h b=%h got %h/%b/%b want %h/%b/%b",
                 pa, pb, sum_q, cout_q, ovf_q, exp_sum, exp_cout, exp_ovf);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_directed;
    test_group_boundaries;
    test_random;
    test_registered;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule
